// File: rtl/digit_window_scanner_pkg.sv
// Shared types and seven-segment glyph constants for the digit window scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package disp_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;

endpackage

// File: rtl/digit_window_scanner_bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder; non-BCD nibbles render as a dash.
module bcd_to_7seg
    import disp_pkg::*;
(
    input  bcd_digit_t digit_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/digit_window_scanner.sv
// Scans a clamped DISPLAY_DIGITS-wide window of a BCD value onto a multiplexed
// seven-segment display, with per-frame snapshot and per-slot anti-ghost blanking.
module digit_window_scanner
    import disp_pkg::*;
#(
    parameter int DISPLAY_DIGITS = 6,
    parameter int TOTAL_DIGITS   = 17,
    parameter int SHIFT_AMT_W    = 4,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic [SHIFT_AMT_W-1:0]      shift_amount,
    input  logic [4*TOTAL_DIGITS-1:0]   value_bcd,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [DISPLAY_DIGITS-1:0]   an,
    output logic                        frame_start
);

    localparam int MAX_START = TOTAL_DIGITS - DISPLAY_DIGITS;
    localparam int PRESC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W     = (DISPLAY_DIGITS > 1) ? $clog2(DISPLAY_DIGITS) : 1;
    localparam logic [DISPLAY_DIGITS-1:0] AN_ONE = DISPLAY_DIGITS'(1);

    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   first_q, first_d;
    logic [SHIFT_AMT_W-1:0] win_q, win_d;
    bcd_digit_t             snap_q [DISPLAY_DIGITS];
    bcd_digit_t             snap_d [DISPLAY_DIGITS];

    logic [DISPLAY_DIGITS-1:0] an_q, an_d;
    seg_t                      seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      fs_q, fs_d;

    logic                      presc_wrap, idx_wrap, take;
    logic [SHIFT_AMT_W-1:0]    win_clamp;
    logic [4*TOTAL_DIGITS-1:0] window_bits;
    bcd_digit_t                cur_digit;
    seg_t                      glyph;
    logic                      blank;

    assign presc_wrap = (presc_q == PRESC_W'(SCAN_DIV - 1));
    assign idx_wrap   = (idx_q == IDX_W'(DISPLAY_DIGITS - 1));
    assign take       = ena && (first_q || (presc_wrap && idx_wrap));
    assign win_clamp  = (shift_amount > SHIFT_AMT_W'(MAX_START)) ? SHIFT_AMT_W'(MAX_START)
                                                                 : shift_amount;
    assign window_bits = value_bcd >> {win_clamp, 2'b00};

    // Counter and snapshot next-state; everything holds while ena is low.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        first_d = first_q;
        win_d   = win_q;
        for (int i = 0; i < DISPLAY_DIGITS; i++) snap_d[i] = snap_q[i];
        if (ena) begin
            first_d = 1'b0;
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) idx_d = idx_wrap ? '0 : idx_q + 1'b1;
        end
        if (take) begin
            win_d = win_clamp;
            for (int i = 0; i < DISPLAY_DIGITS; i++) snap_d[i] = window_bits[4*i +: 4];
        end
    end

    always_comb begin
        cur_digit = snap_q[0];
        for (int i = 0; i < DISPLAY_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_digit = snap_q[i];
        end
    end

    bcd_to_7seg u_dec (
        .digit_i (cur_digit),
        .seg_o   (glyph)
    );

    // Output next-state, registered one cycle behind the counters.
    always_comb begin
        blank = !ena || (presc_q < PRESC_W'(BLANK_CYCLES));
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        fs_d  = take;
        if (!blank) begin
            an_d  = ~(AN_ONE << idx_q);
            seg_d = glyph;
            dp_d  = !(((idx_q == '0) && (win_q != '0)) ||
                      (idx_wrap && (win_q < SHIFT_AMT_W'(MAX_START))));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
            win_q   <= '0;
            for (int i = 0; i < DISPLAY_DIGITS; i++) snap_q[i] <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            win_q   <= win_d;
            for (int i = 0; i < DISPLAY_DIGITS; i++) snap_q[i] <= snap_d[i];
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_digit_window_scanner.sv
// Randomized and directed bench for digit_window_scanner against a slot-arithmetic
// reference model (SCAN_DIV=4, BLANK_CYCLES=1, 17 total digits, 6 displayed).
module tb_digit_window_scanner;

    localparam int DD  = 6;
    localparam int TD  = 17;
    localparam int SD  = 4;
    localparam int BC  = 1;
    localparam int MAXW = TD - DD;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ena = 1'b1;
    logic [3:0]      shift_amount = '0;
    logic [4*TD-1:0] value_bcd = '0;
    logic [6:0]      seg;
    logic            dp;
    logic [DD-1:0]   an;
    logic            frame_start;

    int n_assert = 0;
    int n_fail   = 0;

    int k = 0;
    int m_win = 0;
    int m_snap [DD];

    always #5 clk = ~clk;

    digit_window_scanner #(
        .DISPLAY_DIGITS (DD),
        .TOTAL_DIGITS   (TD),
        .SHIFT_AMT_W    (4),
        .SCAN_DIV       (SD),
        .BLANK_CYCLES   (BC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .shift_amount (shift_amount),
        .value_bcd    (value_bcd),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .frame_start  (frame_start)
    );

    function automatic logic [6:0] glyph(int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d >= 0 && d <= 9) ? tbl[d] : 7'h3F;
    endfunction

    function automatic int cur_idx();
        return (k / SD) % DD;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the pre-edge state and inputs, then compare after the edge.
    task automatic tick();
        logic [DD-1:0] e_an;
        logic [6:0]    e_seg;
        logic          e_dp, e_fs;
        int p, i;
        e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        if (!rst_n) begin
            k = 0;
            m_win = 0;
            for (int j = 0; j < DD; j++) m_snap[j] = 0;
        end else if (ena) begin
            p = k % SD;
            i = (k / SD) % DD;
            if (p >= BC) begin
                e_an  = ~(DD'(1) << i);
                e_seg = glyph(m_snap[i]);
                e_dp  = !((i == 0 && m_win > 0) || (i == DD-1 && m_win < MAXW));
            end
            e_fs = (k == 0) || (k % (SD*DD) == SD*DD - 1);
            if (e_fs) begin
                m_win = (int'(shift_amount) > MAXW) ? MAXW : int'(shift_amount);
                for (int j = 0; j < DD; j++) m_snap[j] = int'(value_bcd[4*(m_win+j) +: 4]);
            end
            k++;
        end
        @(posedge clk);
        #1;
        check("an", 8'(an), 8'(e_an));
        check("seg", 8'(seg), 8'(e_seg));
        check("dp", 8'(dp), 8'(e_dp));
        check("frame_start", 8'(frame_start), 8'(e_fs));
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    initial begin
        int pulses;
        int guard;
        for (int d = 0; d < TD; d++) value_bcd[4*d +: 4] = 4'((d + 1) % 10);

        // Reset held three cycles.
        rst_n = 1'b0; ena = 1'b1; shift_amount = 4'd0;
        run(3);
        check("rst_an", 8'(an), 8'h3F);

        // Release: exactly one frame_start pulse before the next frame boundary.
        rst_n = 1'b1;
        pulses = 0;
        tick();
        if (frame_start === 1'b1) pulses++;
        tick();
        check("first_an", 8'(an), 8'h3E);
        check("first_seg", 8'(seg), 8'h79);
        for (int t = 0; t < 21; t++) begin
            tick();
            if (frame_start === 1'b1) pulses++;
        end
        check("pulse_count", 8'(pulses), 8'd1);
        run(25);

        // Window shifts and clamp.
        shift_amount = 4'd3;
        run(48);
        shift_amount = 4'd15;
        run(48);

        // Tear-free: change window in the middle of a frame.
        shift_amount = 4'd0;
        run(24);
        guard = 0;
        while (cur_idx() != 3 && guard < 30) begin tick(); guard++; end
        check("reach_idx3", 8'(cur_idx()), 8'd3);
        shift_amount = 4'd2;
        run(48);

        // Invalid nibble and enable hold.
        shift_amount = 4'd0;
        value_bcd[3:0] = 4'hC;
        run(30);
        ena = 1'b0;
        run(10);
        ena = 1'b1;
        run(30);

        // Mid-frame reset.
        guard = 0;
        while (cur_idx() != 4 && guard < 30) begin tick(); guard++; end
        check("reach_idx4", 8'(cur_idx()), 8'd4);
        rst_n = 1'b0;
        tick();
        check("midrst_an", 8'(an), 8'h3F);
        rst_n = 1'b1;
        run(30);

        // Randomized traffic.
        for (int t = 0; t < 500; t++) begin
            if ($urandom_range(0, 4) == 0) shift_amount = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                for (int d = 0; d < TD; d++) value_bcd[4*d +: 4] = 4'($urandom_range(0, 15));
            end
            ena   = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
